// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the handshaked multicycle main controller: state codes,
// instruction opcodes, datapath mux selects and the per-state Moore output table.
package mc_ctrl_pkg;

    localparam int STATE_CODE_W = 4;

    typedef enum logic [STATE_CODE_W-1:0] {
        ST_FETCH      = 4'd0,
        ST_DECODE     = 4'd1,
        ST_MEMADR     = 4'd2,
        ST_MEMREAD    = 4'd3,
        ST_MEMWB      = 4'd4,
        ST_MEMWRITE   = 4'd5,
        ST_EXECR      = 4'd6,
        ST_EXECI      = 4'd7,
        ST_ALUWB      = 4'd8,
        ST_BRANCH     = 4'd9,
        ST_BRANCHLINK = 4'd10,
        ST_FAULT      = 4'd11
    } state_e;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Registered Moore control word, one field per datapath control.
    typedef struct packed {
        logic       mem_req;
        logic       mem_w;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       reg_w;
        logic       branch;
        logic       bl_active;
    } ctrl_t;

    // FAULT and any unassigned code fall through to the all-zero word.
    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH, ST_DECODE: begin
                c.mem_req    = (s == ST_FETCH);
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_4;
                c.result_src = RES_ALU;
            end
            ST_MEMADR: begin
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALU;
            end
            ST_MEMREAD: begin
                c.mem_req    = 1'b1;
                c.adr_src    = 1'b1;
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALUOUT;
            end
            ST_MEMWB: begin
                c.adr_src    = 1'b1;
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_DATA;
                c.reg_w      = 1'b1;
            end
            ST_MEMWRITE: begin
                c.mem_req    = 1'b1;
                c.mem_w      = 1'b1;
                c.adr_src    = 1'b1;
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALUOUT;
            end
            ST_EXECR: begin
                c.adr_src    = 1'b1;
                c.alu_src_b  = SRCB_REG;
                c.result_src = RES_ALUOUT;
                c.alu_op     = 1'b1;
            end
            ST_EXECI: begin
                c.adr_src    = 1'b1;
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALUOUT;
                c.alu_op     = 1'b1;
            end
            ST_ALUWB: begin
                c.adr_src    = 1'b1;
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALUOUT;
                c.reg_w      = 1'b1;
            end
            ST_BRANCH, ST_BRANCHLINK: begin
                c.adr_src    = 1'b1;
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALU;
                c.branch     = 1'b1;
                c.reg_w      = (s == ST_BRANCHLINK);
                c.bl_active  = (s == ST_BRANCHLINK);
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_main_fsm_hs_if.sv
// Instruction-field, memory-handshake and datapath-control bundle between the
// main controller (slave side) and the datapath/memory environment (master side).
interface mc_main_fsm_hs_if #(
    parameter int STATE_W = 4
);
    logic [1:0]         Op;
    logic [5:0]         Funct;
    logic [3:0]         Rd;
    logic               MemReady;

    logic               MemReq;
    logic               MemW;
    logic               IRWrite;
    logic               NextPC;
    logic               AdrSrc;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ResultSrc;
    logic               ALUOp;
    logic               RegW;
    logic               Branch;
    logic               BL_Active;
    logic               PCS;
    logic               Fault;
    logic [STATE_W-1:0] State;

    modport master (
        output Op, Funct, Rd, MemReady,
        input  MemReq, MemW, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, Branch, BL_Active, PCS, Fault, State
    );

    modport slave (
        input  Op, Funct, Rd, MemReady,
        output MemReq, MemW, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, Branch, BL_Active, PCS, Fault, State
    );

endinterface

// File: rtl/mc_wait_timer.sv
// Wait-state counter for one memory access; expired flags that the access has
// waited TIMEOUT cycles without completion (never asserts when TIMEOUT is 0).
module mc_wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT > 0) && (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mc_main_fsm_hs.sv
// Multicycle ARM main controller with a request/ready memory handshake, a
// wait-state watchdog, an undefined-instruction trap and a sticky fault state.
module mc_main_fsm_hs
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W    = 4,   // >= 4
    parameter int TIMEOUT    = 15,
    parameter int TRAP_UNDEF = 1,
    parameter int CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic            CLK,
    input  logic            RESET,
    mc_main_fsm_hs_if.slave bus
);

    state_e state_q;
    state_e next_state;
    ctrl_t  ctrl_q;
    logic   fault_q;
    logic   expired;
    logic   timer_clear;
    logic   timer_enable;
    logic   unused_funct;

    assign unused_funct = ^bus.Funct[3:1];

    // The counter only runs while a request is outstanding and unanswered; it
    // freezes at TIMEOUT so the fault transition sees a stable value.
    assign timer_clear  = !ctrl_q.mem_req || bus.MemReady;
    assign timer_enable = ctrl_q.mem_req && !bus.MemReady && !expired;

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (expired)
    );

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = ST_FAULT;
        case (state_q)
            ST_FETCH: begin
                if (bus.MemReady)  next_state = ST_DECODE;
                else if (expired)  next_state = ST_FAULT;
                else               next_state = ST_FETCH;
            end
            ST_DECODE: begin
                case (bus.Op)
                    OP_DP:   next_state = bus.Funct[5] ? ST_EXECI : ST_EXECR;
                    OP_MEM:  next_state = ST_MEMADR;
                    OP_BR:   next_state = bus.Funct[4] ? ST_BRANCHLINK : ST_BRANCH;
                    default: next_state = (TRAP_UNDEF != 0) ? ST_FAULT : ST_FETCH;
                endcase
            end
            ST_MEMADR:
                next_state = bus.Funct[0] ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD: begin
                if (bus.MemReady)  next_state = ST_MEMWB;
                else if (expired)  next_state = ST_FAULT;
                else               next_state = ST_MEMREAD;
            end
            ST_MEMWRITE: begin
                if (bus.MemReady)  next_state = ST_FETCH;
                else if (expired)  next_state = ST_FAULT;
                else               next_state = ST_MEMWRITE;
            end
            ST_EXECR, ST_EXECI:
                next_state = ST_ALUWB;
            ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_BRANCHLINK:
                next_state = ST_FETCH;
            default:
                next_state = ST_FAULT;
        endcase
    end

    // Outputs are registered from next_state so they line up with state_q; the
    // async reset therefore drops MemW and restarts the fetch request at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_FETCH;
            ctrl_q  <= state_ctrl(ST_FETCH);
            fault_q <= 1'b0;
        end else begin
            state_q <= next_state;
            ctrl_q  <= state_ctrl(next_state);
            fault_q <= fault_q || (next_state == ST_FAULT);
        end
    end

    assign bus.MemReq    = ctrl_q.mem_req;
    assign bus.MemW      = ctrl_q.mem_w;
    assign bus.AdrSrc    = ctrl_q.adr_src;
    assign bus.ALUSrcA   = ctrl_q.alu_src_a;
    assign bus.ALUSrcB   = ctrl_q.alu_src_b;
    assign bus.ResultSrc = ctrl_q.result_src;
    assign bus.ALUOp     = ctrl_q.alu_op;
    assign bus.RegW      = ctrl_q.reg_w;
    assign bus.Branch    = ctrl_q.branch;
    assign bus.BL_Active = ctrl_q.bl_active;
    assign bus.Fault     = fault_q;
    assign bus.State     = STATE_W'(state_q);

    // Mealy pulse: one IR load and one PC+4 however many wait cycles the fetch took.
    assign bus.IRWrite   = (state_q == ST_FETCH) && bus.MemReady;
    assign bus.NextPC    = (state_q == ST_FETCH) && bus.MemReady;

    assign bus.PCS       = ((bus.Rd == 4'd15) && ctrl_q.reg_w) || ctrl_q.branch;

endmodule

// File: tb/tb_mc_main_fsm_hs.sv
// Scoreboard bench for mc_main_fsm_hs: per-cycle expectations are queued with the
// stimulus and compared on the falling edge; a second instance has the trap disabled.
module tb_mc_main_fsm_hs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] op = '0;
    logic [5:0] funct = '0;
    logic [3:0] rd = '0;
    logic       mem_ready = 1'b0;

    always #5 clk = ~clk;

    mc_main_fsm_hs_if #(.STATE_W(4)) bus ();
    mc_main_fsm_hs_if #(.STATE_W(4)) bus_nt ();

    assign bus.Op          = op;
    assign bus.Funct       = funct;
    assign bus.Rd          = rd;
    assign bus.MemReady    = mem_ready;
    assign bus_nt.Op       = op;
    assign bus_nt.Funct    = funct;
    assign bus_nt.Rd       = rd;
    assign bus_nt.MemReady = mem_ready;

    mc_main_fsm_hs #(.STATE_W(4), .TIMEOUT(15), .TRAP_UNDEF(1)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    mc_main_fsm_hs #(.STATE_W(4), .TIMEOUT(15), .TRAP_UNDEF(0)) dut_nt (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_nt)
    );

    typedef enum {
        S_STATE, S_STATE_NT, S_FAULT_NT, S_MEMREQ, S_MEMW, S_IRW, S_NPC, S_ADRSRC,
        S_SRCA, S_SRCB, S_RES, S_ALUOP, S_REGW, S_BRANCH, S_BL, S_PCS, S_FAULT
    } sel_e;

    typedef struct {
        int    cyc;
        sel_e  sel;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int observe(input sel_e s);
        case (s)
            S_STATE:    return int'(bus.State);
            S_STATE_NT: return int'(bus_nt.State);
            S_FAULT_NT: return int'(bus_nt.Fault);
            S_MEMREQ:   return int'(bus.MemReq);
            S_MEMW:     return int'(bus.MemW);
            S_IRW:      return int'(bus.IRWrite);
            S_NPC:      return int'(bus.NextPC);
            S_ADRSRC:   return int'(bus.AdrSrc);
            S_SRCA:     return int'(bus.ALUSrcA);
            S_SRCB:     return int'(bus.ALUSrcB);
            S_RES:      return int'(bus.ResultSrc);
            S_ALUOP:    return int'(bus.ALUOp);
            S_REGW:     return int'(bus.RegW);
            S_BRANCH:   return int'(bus.Branch);
            S_BL:       return int'(bus.BL_Active);
            S_PCS:      return int'(bus.PCS);
            S_FAULT:    return int'(bus.Fault);
            default:    return -1;
        endcase
    endfunction

    // Expectation dc cycles after the current one; the queue is kept cycle-ordered.
    task automatic expect_at(input int dc, input string tag, input sel_e s, input int v);
        exp_t e;
        int   idx;
        e.cyc = cyc + dc;
        e.sel = s;
        e.val = v;
        e.tag = $sformatf("%s@+%0d", tag, dc);
        idx = sb.size();
        while (idx > 0 && sb[idx-1].cyc > e.cyc) idx--;
        sb.insert(idx, e);
    endtask

    // n per-cycle values packed as hex nibbles, first cycle in the leftmost nibble.
    task automatic expect_seq(input string tag, input sel_e s, input logic [63:0] seq, input int n);
        for (int i = 0; i < n; i++) expect_at(i, tag, s, int'(seq[(n-1-i)*4 +: 4]));
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            check(mon_e.tag, observe(mon_e.sel), mon_e.val);
        end
    end

    task step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_dp(input logic [5:0] f, input logic [3:0] exec_st, input logic [1:0] srcb);
        expect_seq("dp_state", S_STATE, {44'd0, 4'h0, 4'h1, exec_st, 4'h8, 4'h0}, 5);
        expect_seq("dp_aluop", S_ALUOP, 64'h00100, 5);
        expect_seq("dp_regw",  S_REGW,  64'h00010, 5);
        expect_seq("dp_pcs",   S_PCS,   64'h00000, 5);
        expect_at(0, "dp_irw", S_IRW, 1);
        expect_at(2, "dp_srcb", S_SRCB, int'(srcb));
        op = 2'b00; funct = f; rd = 4'd3; mem_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic run_ldr();
        expect_seq("ldr_state",  S_STATE,  64'h012333340, 9);
        expect_seq("ldr_regw",   S_REGW,   64'h000000010, 9);
        expect_seq("ldr_memreq", S_MEMREQ, 64'h100111101, 9);
        expect_at(7, "ldr_res", S_RES, 1);
        expect_at(7, "ldr_adrsrc", S_ADRSRC, 1);
        op = 2'b01; funct = 6'b000001; rd = 4'd5;
        for (int i = 0; i < 8; i++) begin
            mem_ready = !(i >= 3 && i <= 5);
            step();
        end
    endtask

    task automatic run_fetch_wait();
        expect_seq("fw_irw",   S_IRW,   64'h000001000, 9);
        expect_seq("fw_npc",   S_NPC,   64'h000001000, 9);
        expect_seq("fw_state", S_STATE, 64'h0000001680, 10);
        expect_seq("fw_fault", S_FAULT, 64'h0, 10);
        expect_seq("fw_pcs",   S_PCS,   64'h0000000010, 10);
        op = 2'b00; funct = 6'b000000; rd = 4'd15;
        for (int i = 0; i < 9; i++) begin
            mem_ready = (i >= 5);
            step();
        end
    endtask

    task automatic run_branch(input logic link);
        logic [3:0] br_st = link ? 4'hA : 4'h9;
        logic [3:0] l = {3'b000, link};
        expect_seq("br_state",  S_STATE,  {48'd0, 4'h0, 4'h1, br_st, 4'h0}, 4);
        expect_seq("br_regw",   S_REGW,   {48'd0, 8'h00, l, 4'h0}, 4);
        expect_seq("br_bl",     S_BL,     {48'd0, 8'h00, l, 4'h0}, 4);
        expect_seq("br_branch", S_BRANCH, 64'h0010, 4);
        expect_seq("br_pcs",    S_PCS,    64'h0010, 4);
        op = 2'b10; funct = link ? 6'b011010 : 6'b101010; rd = 4'd3; mem_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic run_str_timeout();
        expect_seq("str_state", S_STATE, 64'h012, 3);
        expect_at(2, "str_memw", S_MEMW, 0);
        for (int i = 0; i < 16; i++) expect_at(3 + i, "str_memw", S_MEMW, 1);
        expect_at(3,  "str_state", S_STATE, 5);
        expect_at(18, "str_state", S_STATE, 5);
        expect_at(18, "str_fault", S_FAULT, 0);
        expect_at(19, "str_state", S_STATE, 11);
        expect_at(19, "str_fault", S_FAULT, 1);
        expect_at(19, "str_memw", S_MEMW, 0);
        expect_at(19, "str_memreq", S_MEMREQ, 0);
        expect_at(21, "str_state", S_STATE, 11);
        expect_at(21, "str_fault", S_FAULT, 1);
        op = 2'b01; funct = 6'b000000; rd = 4'd0;
        for (int i = 0; i < 22; i++) begin
            mem_ready = (i < 2 || i >= 19);
            step();
        end
        rst = 1'b1;
        #1;
        check("str_rst_state", int'(bus.State), 0);
        check("str_rst_fault", int'(bus.Fault), 0);
        step();
        rst = 1'b0;
    endtask

    task automatic run_reset_mid_write();
        expect_seq("rmw_state", S_STATE, 64'h0125, 4);
        expect_at(3, "rmw_memw", S_MEMW, 1);
        op = 2'b01; funct = 6'b000000; rd = 4'd0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i < 2);
            step();
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rmw_async_state", int'(bus.State), 0);
        check("rmw_async_memw", int'(bus.MemW), 0);
        check("rmw_async_memreq", int'(bus.MemReq), 1);
        step();
        rst = 1'b0;
    endtask

    task automatic run_undef();
        expect_seq("ud_state",    S_STATE,    64'h01BB, 4);
        expect_seq("ud_fault",    S_FAULT,    64'h0011, 4);
        expect_seq("ud_nt_state", S_STATE_NT, 64'h0101, 4);
        expect_at(2, "ud_nt_fault", S_FAULT_NT, 0);
        expect_at(2, "ud_regw", S_REGW, 0);
        op = 2'b11; funct = 6'b000000; rd = 4'd0; mem_ready = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",  int'(bus.State), 0);
        check("rst_memreq", int'(bus.MemReq), 1);
        check("rst_memw",   int'(bus.MemW), 0);
        check("rst_srca",   int'(bus.ALUSrcA), 1);
        check("rst_srcb",   int'(bus.ALUSrcB), 2);
        check("rst_res",    int'(bus.ResultSrc), 2);
        check("rst_adrsrc", int'(bus.AdrSrc), 0);
        check("rst_aluop",  int'(bus.ALUOp), 0);
        check("rst_regw",   int'(bus.RegW), 0);
        check("rst_irw",    int'(bus.IRWrite), 0);
        check("rst_fault",  int'(bus.Fault), 0);
        rst = 1'b0;

        run_dp(6'b001000, 4'h6, 2'b00);
        run_dp(6'b101000, 4'h7, 2'b01);
        run_ldr();
        run_fetch_wait();
        run_branch(1'b1);
        run_branch(1'b0);
        run_str_timeout();
        run_reset_mid_write();
        run_undef();

        repeat (2) step();
        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
